// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl -- program sequencer / run controller
//
// Loads a program counter from one of NPROG entry points, steps it through an
// instruction stream (sequential, absolute jump, or zero-qualified relative
// branch) until a halt opcode or the optional watchdog ends the run.
//
// Ports
//   Clk          in   clock, rising edge
//   Reset        in   asynchronous active-low reset
//   Start        in   level request to (re)load and run; wins in every state
//   ProgSel      in   entry-point index, sampled while Start=1
//   BaseAddr     in   packed entry addresses, entry k = BaseAddr[k*PW +: PW]
//   Instruction  in   instruction at ProgCtr; opcode is the top OPW bits
//   BranchAbs    in   absolute jump to Target (priority over relative branch)
//   BranchRelEn  in   relative branch enable, taken only when Zero=1
//   Zero         in   ALU zero flag
//   Target       in   jump address or two's-complement branch offset
//   ProgCtr      out  program counter (registered)
//   Run          out  high while the sequencer is in RUN (decoded from state)
//   Ack          out  sticky done flag (registered)
//   Timeout      out  sticky watchdog-expired flag (registered)
//   CycleCt      out  executed-instruction count, saturating (registered)
// ---------------------------------------------------------------------------
module run_ctrl #(
    parameter int              PW       = 10,
    parameter int              IW       = 9,
    parameter int              OPW      = 4,
    parameter logic [OPW-1:0]  HALT_OP  = 4'b1101,
    parameter int              NPROG    = 4,
    parameter int              CW       = 16,
    parameter int              WDOG_LIM = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [$clog2(NPROG)-1:0]  ProgSel,
    input  logic [NPROG*PW-1:0]       BaseAddr,
    input  logic [IW-1:0]             Instruction,
    input  logic                      BranchAbs,
    input  logic                      BranchRelEn,
    input  logic                      Zero,
    input  logic [PW-1:0]             Target,
    output logic [PW-1:0]             ProgCtr,
    output logic                      Run,
    output logic                      Ack,
    output logic                      Timeout,
    output logic [CW-1:0]             CycleCt
);

    localparam int SW    = $clog2(NPROG);
    localparam int NSLOT = 1 << SW;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        TOUT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            ack_q, ack_d;
    logic            tout_q, tout_d;

    // Entry table padded to a power of two so any ProgSel value indexes a
    // defined slot; unused slots select address 0.
    logic [PW-1:0]   entry_tab [NSLOT];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_entry
            if (gi < NPROG) begin : g_used
                assign entry_tab[gi] = BaseAddr[gi*PW +: PW];
            end else begin : g_unused
                assign entry_tab[gi] = '0;
            end
        end
    endgenerate

    logic [OPW-1:0]  opcode;
    logic            is_halt;
    logic            wdog_hit;

    assign opcode   = Instruction[IW-1 -: OPW];
    assign is_halt  = (opcode == HALT_OP);
    // The watchdog fires on the instruction that would be counted past the
    // limit; a zero limit removes the comparison entirely.
    assign wdog_hit = (WDOG_LIM != 0) && (cyc_q == CW'(WDOG_LIM));

    // -----------------------------------------------------------------------
    // Next-state / datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        ack_d   = ack_q;
        tout_d  = tout_q;

        if (Start) begin
            // Start overrides everything, including an active run.
            state_d = LOAD;
            pc_d    = entry_tab[ProgSel];
            cyc_d   = '0;
            ack_d   = 1'b0;
            tout_d  = 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (is_halt) begin
                        // Halt beats the watchdog when both hit together.
                        state_d = DONE;
                        ack_d   = 1'b1;
                    end else if (wdog_hit) begin
                        state_d = TOUT;
                        ack_d   = 1'b1;
                        tout_d  = 1'b1;
                    end else begin
                        if (BranchAbs) begin
                            pc_d = Target;
                        end else if (BranchRelEn && Zero) begin
                            pc_d = pc_q + Target;
                        end else begin
                            pc_d = pc_q + PW'(1);
                        end
                        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CW'(1);
                    end
                end
                default: begin
                    // IDLE, DONE, TOUT hold everything.
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cyc_q   <= '0;
            ack_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            ack_q   <= ack_d;
            tout_q  <= tout_d;
        end
    end

    assign ProgCtr = pc_q;
    assign CycleCt = cyc_q;
    assign Ack     = ack_q;
    assign Timeout = tout_q;
    assign Run     = (state_q == RUN);

endmodule

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl -- self-checking bench for run_ctrl
//
// Two instances share all inputs: one with the watchdog disabled and one with
// WDOG_LIM=8. A behavioural model of each run (idle / loading / running /
// finished, plain integer arithmetic) predicts every output after every clock.
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int PW = 10;
    localparam int CW = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       prog_sel;
    logic [4*PW-1:0]  base_addr;
    logic [8:0]       instr;
    logic             babs, brel, zero;
    logic [PW-1:0]    tgt;

    logic [PW-1:0]    pc0, pc8;
    logic             run0, run8, ack0, ack8, tout0, tout8;
    logic [CW-1:0]    cyc0, cyc8;

    int total = 0;
    int bad   = 0;

    int base [4] = '{'h000, 'h040, 'h100, 'h3F0};

    localparam logic [8:0] NOP  = 9'h000;
    localparam logic [8:0] HALT = 9'h1A0;   // opcode 4'b1101

    // phase: 0 idle, 1 loading, 2 running, 3 finished (halt or timeout)
    typedef struct {
        int phase;
        int pc;
        int cnt;
        int ack;
        int tout;
    } m_t;

    m_t m0, m8;

    run_ctrl #(.WDOG_LIM(0)) dut0 (
        .Clk(clk), .Reset(rst_n), .Start(start), .ProgSel(prog_sel),
        .BaseAddr(base_addr), .Instruction(instr), .BranchAbs(babs),
        .BranchRelEn(brel), .Zero(zero), .Target(tgt),
        .ProgCtr(pc0), .Run(run0), .Ack(ack0), .Timeout(tout0), .CycleCt(cyc0)
    );

    run_ctrl #(.WDOG_LIM(8)) dut8 (
        .Clk(clk), .Reset(rst_n), .Start(start), .ProgSel(prog_sel),
        .BaseAddr(base_addr), .Instruction(instr), .BranchAbs(babs),
        .BranchRelEn(brel), .Zero(zero), .Target(tgt),
        .ProgCtr(pc8), .Run(run8), .Ack(ack8), .Timeout(tout8), .CycleCt(cyc8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic m_t m_reset();
        m_t r;
        r.phase = 0; r.pc = 0; r.cnt = 0; r.ack = 0; r.tout = 0;
        return r;
    endfunction

    function automatic m_t m_step(input m_t m, input int lim, input bit st,
                                  input int sel, input int ins, input bit ba,
                                  input bit br, input bit z, input int t);
        m_t n = m;
        if (st) begin
            n.phase = 1; n.pc = base[sel]; n.cnt = 0; n.ack = 0; n.tout = 0;
        end else if (m.phase == 1) begin
            n.phase = 2;
        end else if (m.phase == 2) begin
            if ((ins >> 5) == 13) begin
                n.phase = 3; n.ack = 1;
            end else if (lim != 0 && m.cnt == lim) begin
                n.phase = 3; n.ack = 1; n.tout = 1;
            end else begin
                if (ba)           n.pc = t;
                else if (br && z) n.pc = (m.pc + t) % 1024;
                else              n.pc = (m.pc + 1) % 1024;
                n.cnt = (m.cnt == 65535) ? m.cnt : m.cnt + 1;
            end
        end
        return n;
    endfunction

    task automatic check_all();
        check_val("pc_w0",   int'(pc0),   m0.pc);
        check_val("run_w0",  int'(run0),  int'(m0.phase == 2));
        check_val("ack_w0",  int'(ack0),  m0.ack);
        check_val("tout_w0", int'(tout0), m0.tout);
        check_val("cyc_w0",  int'(cyc0),  m0.cnt);
        check_val("pc_w8",   int'(pc8),   m8.pc);
        check_val("run_w8",  int'(run8),  int'(m8.phase == 2));
        check_val("ack_w8",  int'(ack8),  m8.ack);
        check_val("tout_w8", int'(tout8), m8.tout);
        check_val("cyc_w8",  int'(cyc8),  m8.cnt);
    endtask

    // One clock: apply inputs, advance both models, compare after the edge.
    task automatic step(input bit st, input int sel, input logic [8:0] ins,
                        input bit ba, input bit br, input bit z, input int t);
        start = st; prog_sel = 2'(sel); instr = ins;
        babs = ba; brel = br; zero = z; tgt = PW'(t);
        if (rst_n) begin
            m0 = m_step(m0, 0, st, sel, int'(ins), ba, br, z, t);
            m8 = m_step(m8, 8, st, sel, int'(ins), ba, br, z, t);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(0, 0, NOP, 0, 0, 0, 0);
    endtask

    // Pulse Start for one cycle, let LOAD pass, then run n sequential steps.
    task automatic run_to(input int sel, input int n);
        step(1, sel, NOP, 0, 0, 0, 0);
        step(0, sel, NOP, 0, 0, 0, 0);
        nops(n);
    endtask

    // Async reset asserted between edges; outputs must drop before any edge.
    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        m0 = m_reset();
        m8 = m_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        base_addr = {10'h3F0, 10'h100, 10'h040, 10'h000};
        rst_n = 1'b0; start = 1'b0; prog_sel = '0; instr = NOP;
        babs = 1'b0; brel = 1'b0; zero = 1'b0; tgt = '0;
        m0 = m_reset();
        m8 = m_reset();

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check_all();
        rst_n = 1'b1;
        nops(2);
        $display("txn reset: pc=0x%0h run=%0d ack=%0d", pc0, run0, ack0);

        // Entry 2, five sequential instructions, then halt
        step(1, 2, NOP, 0, 0, 0, 0);
        check_val("r40_load_pc", int'(pc0), 'h100);
        step(0, 2, NOP, 0, 0, 0, 0);
        check_val("r40_run", int'(run0), 1);
        nops(5);
        step(0, 0, HALT, 0, 0, 0, 0);
        nops(3);
        check_val("r40_cyc", int'(cyc0), 5);
        check_val("r40_pc", int'(pc0), 'h105);
        check_val("r40_ack", int'(ack0), 1);
        $display("txn halt: pc=0x%0h cyc=%0d ack=%0d", pc0, cyc0, ack0);

        // Relative branch taken (negative offset), not taken, and abs priority
        run_to(0, 16);
        step(0, 0, NOP, 0, 1, 1, 'h3FE);
        check_val("r41_rel_taken", int'(pc0), 'h00E);
        run_to(0, 16);
        step(0, 0, NOP, 0, 1, 0, 'h3FE);
        check_val("r41_rel_not", int'(pc0), 'h011);
        run_to(0, 16);
        step(0, 0, NOP, 1, 1, 1, 'h200);
        check_val("r41_abs_prio", int'(pc0), 'h200);
        // Branch inputs outside RUN must not move the counter
        step(0, 0, HALT, 0, 0, 0, 0);
        step(0, 0, NOP, 1, 1, 1, 'h155);
        check_val("r36_ignored", int'(pc0), 'h200);
        $display("txn branch: pc=0x%0h", pc0);

        // Wrap from 0x3FF through 0x000
        run_to(3, 20);
        check_val("r42_wrap", int'(pc0), 'h004);
        $display("txn wrap: pc=0x%0h", pc0);

        // Watchdog on an infinite loop, then halt on the limit cycle
        step(1, 0, NOP, 0, 0, 0, 0);
        step(0, 0, NOP, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, NOP, 1, 0, 0, 0);
        check_val("r43_tout", int'(tout8), 1);
        check_val("r43_ack", int'(ack8), 1);
        check_val("r43_cyc", int'(cyc8), 8);
        nops(2);
        step(1, 0, NOP, 0, 0, 0, 0);
        step(0, 0, NOP, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, NOP, 1, 0, 0, 0);
        step(0, 0, HALT, 1, 0, 0, 0);
        check_val("r43_halt_tout", int'(tout8), 0);
        check_val("r43_halt_ack", int'(ack8), 1);
        $display("txn wdog: tout=%0d cyc=%0d", tout8, cyc8);

        // Reset mid-run, then restart from DONE with entry 1
        run_to(2, 3);
        async_reset();
        check_val("r44_pc0", int'(pc0), 0);
        nops(2);
        run_to(0, 2);
        step(0, 0, HALT, 0, 0, 0, 0);
        step(1, 1, NOP, 0, 0, 0, 0);
        check_val("r44_ack", int'(ack0), 0);
        check_val("r44_pc", int'(pc0), 'h040);
        $display("txn restart: pc=0x%0h ack=%0d", pc0, ack0);

        // Start held while ProgSel moves
        step(1, 0, NOP, 0, 0, 0, 0);
        step(1, 1, NOP, 0, 0, 0, 0);
        step(1, 2, NOP, 0, 0, 0, 0);
        check_val("r45_pc", int'(pc0), 'h100);
        step(0, 0, NOP, 0, 0, 0, 0);
        check_val("r45_run", int'(run0), 1);
        check_val("r45_run_pc", int'(pc0), 'h100);
        $display("txn held_start: pc=0x%0h run=%0d", pc0, run0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
                     9'($urandom_range(0, 511)), $urandom_range(0, 7) == 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1023)));
            end
        end
        $display("txn random: pc=0x%0h cyc=%0d", pc0, cyc0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
